rgb_matrix_spi_driver: RTL
==========================

# rgb_matrix_spi_driver

Parametrised successor to the 8x8 SPI LED matrix driver. It receives full RGB frames over a mode-0 SPI slave port into a back buffer, and swaps that buffer to the display only at the end of a complete scan, so frames never tear. It scans a ROWS x COLS common-row RGB matrix with per-pixel PWM, a blanking interval between rows, and status pulses for frame completion and errors. It sits between the host SPI link and the matrix row and column pins.

## Interface
- ROWS, default 8: number of matrix rows; must be at least 2.
- COLS, default 8: number of matrix columns; must be at least 1.
- BPC, default 8: PWM bits per colour, range 1..8; the top BPC bits of each received byte are used.
- PRESC, default 1: clk cycles per PWM slot; must be at least 1.
- BLANK_CYCLES, default 4: all-off clk cycles at the start of each row; must be at least 1.
- clk  in  1  system clock; must be at least 4x spi_sclk.
- rst_n  in  1  asynchronous active-low reset.
- spi_sclk, spi_mosi, spi_cs_n  in  1 each  SPI mode 0, MSB first, cs active low; all three are asynchronous to clk.
- enable  in  1  when low, all colour outputs are forced to 0; the scan keeps running.
- row_sel  out  ROWS  one-hot, active-high row drive.
- red_out, green_out, blue_out  out  COLS each  active-high column drive; bit c is column c.
- frame_done  out  1  one-clk pulse on each buffer swap.
- frame_err  out  1  one-clk pulse when a transfer is rejected.
- busy  out  1  synchronised cs is active.

## Operation
- SPI input path:
  - sclk, mosi and cs_n each pass through a 2-flop synchroniser.
  - A rising edge of the synced sclk while synced cs is low shifts in the synced mosi.
  - Every 8 bits produce one byte.
- Frame format:
  - FRAME_BYTES = ROWS*COLS*3.
  - Bytes are row-major, pixel-major, in the order R, G, B.
  - Byte k goes to row k/(COLS*3), column (k/3)%COLS, channel k%3.
- Transfer control:
  - A synced cs falling edge clears the bit counter and the byte pointer.
  - Bytes at index FRAME_BYTES or higher are ignored.
  - A trailing partial byte is discarded.
- Synced cs rising edge:
  - If the byte count equals FRAME_BYTES and no swap is pending, set swap_pending.
  - Otherwise pulse frame_err.
- While swap_pending is set:
  - Incoming bytes are not written to the back buffer.
  - That transfer ends with frame_err.
- Buffers:
  - There are two buffers, front and back, each ROWS*COLS*3*BPC bits.
  - Buffer contents are not reset.
  - A disp_valid flag is cleared by reset; all colour outputs stay 0 until the first swap.
- Scan order per row:
  - BLANK phase for BLANK_CYCLES clks: row_sel = 0, colours = 0.
  - PWM phase for (2^BPC - 1) slots of PRESC clks each: row_sel[r] = 1.
  - In PWM slot s (0-based), colour bit = (pixel > s) & enable & disp_valid.
  - Pixel value 0 is never on; value 2^BPC - 1 is on for every slot.
- Row index wraps ROWS-1 -> 0. Scan end is the last clk of row ROWS-1's PWM phase.
- At scan end with swap_pending set: toggle the front/back select, clear swap_pending, set disp_valid, pulse frame_done.
- If swap_pending is set on the same clk as scan end, the swap waits for the next scan end.
- The state machine has two states, BLANK and PWM. Counters: row, slot, presc, blank.

## Timing
- Reset values:
  - row_sel = 0, all colour outputs = 0.
  - frame_done, frame_err, busy = 0.
  - State = BLANK, row = 0, all counters = 0.
  - swap_pending = 0, disp_valid = 0.
  - The SPI shifter is cleared.
- All outputs are registered.
- Latencies:
  - Pin edge to synced event: 2-3 clks.
  - Synced event to the resulting output: 1 clk.
- Row period = BLANK_CYCLES + (2^BPC - 1)*PRESC clks. With defaults this is 259 clks per row and 2072 clks per scan.
- Swap to displayed data: the first row 0 of the following scan uses the new front buffer.
- Reset asserted mid-transfer or mid-scan aborts everything; the next frame requires a new cs falling edge.

## Structure
- Shared package led_matrix_pkg holds:
  - Channel indices CH_R=0, CH_G=1, CH_B=2.
  - The BYTES_PER_PIXEL=3 constant.
  - The scan state enum {BLANK, PWM}.
- Sub-module spi_byte_rx holds the synchronisers, edge detect and shift register.
  - Outputs: byte_valid pulse, byte[7:0], cs_fall, cs_rise, cs_active.
- Top level holds the write pointer, both buffers, swap logic and scan FSM.

## Test plan
- Reset, then no SPI traffic for 2 scans -> row_sel cycles one-hot 0..7, with 4 all-zero clks between rows; colours stay 0; no frame_done.
- Send 192 bytes of 0xFF -> frame_done exactly once, at the first scan end after cs rises. Next scan: every colour bit is high for all 255 PWM clks of each row.
- Send a frame that is all 0x80 except row 3 = 0xFF -> rows other than 3 have colours high for 128 of 255 slots; row 3 is high for 255.
- Send 100 bytes, then raise cs -> frame_err pulses once, no frame_done, and the displayed data is unchanged.
- Send a second full frame before the first swap -> second transfer yields frame_err; first frame displays; the following frame is accepted normally.
- Hold enable low during a valid display -> colours are 0 while row_sel keeps scanning. Pulse rst_n low mid-transfer -> outputs are 0 and disp_valid is cleared.

Source files
------------

// File: rtl/led_matrix_pkg.sv
// Shared constants and types for the RGB LED matrix driver.
package led_matrix_pkg;

  localparam int unsigned CH_R            = 0;
  localparam int unsigned CH_G            = 1;
  localparam int unsigned CH_B            = 2;
  localparam int unsigned BYTES_PER_PIXEL = 3;

  typedef enum logic {
    BLANK = 1'b0,
    PWM   = 1'b1
  } scan_state_e;

  // Counter width that never collapses to zero bits for n <= 1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_byte_rx.sv
// SPI mode-0 slave byte receiver: synchronisers, edge detection and MSB-first shifter.
module spi_byte_rx (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk_i,
  input  logic       mosi_i,
  input  logic       cs_n_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_o,
  output logic       cs_fall_o,
  output logic       cs_rise_o,
  output logic       cs_active_o
);

  logic [1:0] sclk_sync_q;
  logic [1:0] mosi_sync_q;
  logic [1:0] cs_sync_q;
  logic       sclk_prev_q;
  logic       cs_prev_q;
  logic [1:0] primed_q;
  logic       armed_q;
  logic       in_xfer_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] shift_q;

  logic sclk_s, mosi_s, cs_s;
  logic cs_fall_c, cs_rise_c, shift_en_c;

  assign sclk_s = sclk_sync_q[1];
  assign mosi_s = mosi_sync_q[1];
  assign cs_s   = cs_sync_q[1];

  // A transfer only starts on a cs fall seen after cs was observed high post-reset.
  assign cs_fall_c  = armed_q & cs_prev_q & ~cs_s;
  assign cs_rise_c  = in_xfer_q & ~cs_prev_q & cs_s;
  assign shift_en_c = in_xfer_q & ~cs_s & sclk_s & ~sclk_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q  <= 2'b00;
      mosi_sync_q  <= 2'b00;
      cs_sync_q    <= 2'b11;
      sclk_prev_q  <= 1'b0;
      cs_prev_q    <= 1'b1;
      primed_q     <= 2'b00;
      armed_q      <= 1'b0;
      in_xfer_q    <= 1'b0;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'd0;
      byte_valid_o <= 1'b0;
      byte_o       <= 8'd0;
      cs_fall_o    <= 1'b0;
      cs_rise_o    <= 1'b0;
      cs_active_o  <= 1'b0;
    end else begin
      sclk_sync_q  <= {sclk_sync_q[0], sclk_i};
      mosi_sync_q  <= {mosi_sync_q[0], mosi_i};
      cs_sync_q    <= {cs_sync_q[0], cs_n_i};
      sclk_prev_q  <= sclk_s;
      cs_prev_q    <= cs_s;
      primed_q     <= {primed_q[0], 1'b1};
      byte_valid_o <= 1'b0;
      cs_fall_o    <= cs_fall_c;
      cs_rise_o    <= cs_rise_c;
      cs_active_o  <= ~cs_s;

      if (primed_q[1] && cs_s) begin
        armed_q <= 1'b1;
      end

      if (cs_fall_c) begin
        in_xfer_q <= 1'b1;
      end else if (cs_rise_c) begin
        in_xfer_q <= 1'b0;
      end

      if (cs_fall_c) begin
        bit_cnt_q <= 3'd0;
      end else if (shift_en_c) begin
        shift_q   <= {shift_q[6:0], mosi_s};
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          byte_valid_o <= 1'b1;
          byte_o       <= {shift_q[6:0], mosi_s};
        end
      end
    end
  end

endmodule

// File: rtl/rgb_matrix_spi_driver.sv
// Double-buffered RGB matrix driver: SPI frame load into a back buffer,
// tear-free swap at scan end, row scan with blanking and per-pixel PWM.
module rgb_matrix_spi_driver
  import led_matrix_pkg::*;
#(
  parameter int unsigned ROWS         = 8,
  parameter int unsigned COLS         = 8,
  parameter int unsigned BPC          = 8,
  parameter int unsigned PRESC        = 1,
  parameter int unsigned BLANK_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            spi_sclk,
  input  logic            spi_mosi,
  input  logic            spi_cs_n,
  input  logic            enable,
  output logic [ROWS-1:0] row_sel,
  output logic [COLS-1:0] red_out,
  output logic [COLS-1:0] green_out,
  output logic [COLS-1:0] blue_out,
  output logic            frame_done,
  output logic            frame_err,
  output logic            busy
);

  localparam int unsigned FRAME_BYTES = ROWS * COLS * BYTES_PER_PIXEL;
  localparam int unsigned SLOTS       = (1 << BPC) - 1;
  localparam int unsigned PTR_W       = $clog2(FRAME_BYTES + 1);
  localparam int unsigned IDX_W       = cnt_width(FRAME_BYTES);
  localparam int unsigned ROW_W       = cnt_width(ROWS);
  localparam int unsigned SLOT_W      = BPC;
  localparam int unsigned PRE_W       = cnt_width(PRESC);
  localparam int unsigned BLK_W       = cnt_width(BLANK_CYCLES);

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       cs_fall;
  logic       cs_rise;

  logic [PTR_W-1:0] ptr_q;
  logic             blocked_q;
  logic             swap_pending_q;
  logic             front_sel_q;
  logic             disp_valid_q;

  logic [BPC-1:0] buf_q [2][FRAME_BYTES];

  scan_state_e       state_q;
  logic [ROW_W-1:0]  row_q;
  logic [SLOT_W-1:0] slot_q;
  logic [PRE_W-1:0]  presc_q;
  logic [BLK_W-1:0]  blank_q;

  logic            scan_end_c;
  logic            show_c;
  logic [COLS-1:0] red_d, green_d, blue_d;

  spi_byte_rx u_rx (
    .clk         (clk),
    .rst_n       (rst_n),
    .sclk_i      (spi_sclk),
    .mosi_i      (spi_mosi),
    .cs_n_i      (spi_cs_n),
    .byte_valid_o(byte_valid),
    .byte_o      (byte_data),
    .cs_fall_o   (cs_fall),
    .cs_rise_o   (cs_rise),
    .cs_active_o (busy)
  );

  assign scan_end_c = (state_q == PWM) && (row_q == ROW_W'(ROWS - 1)) &&
                      (slot_q == SLOT_W'(SLOTS - 1)) && (presc_q == PRE_W'(PRESC - 1));

  // Transfer bookkeeping and the front/back swap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q          <= '0;
      blocked_q      <= 1'b0;
      swap_pending_q <= 1'b0;
      front_sel_q    <= 1'b0;
      disp_valid_q   <= 1'b0;
      frame_done     <= 1'b0;
      frame_err      <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;

      if (cs_fall) begin
        ptr_q     <= '0;
        blocked_q <= swap_pending_q;
      end else if (byte_valid) begin
        if (ptr_q < PTR_W'(FRAME_BYTES)) begin
          ptr_q <= ptr_q + PTR_W'(1);
        end
        if (swap_pending_q) begin
          blocked_q <= 1'b1;
        end
      end

      if (cs_rise) begin
        if ((ptr_q == PTR_W'(FRAME_BYTES)) && !swap_pending_q && !blocked_q) begin
          swap_pending_q <= 1'b1;
        end else begin
          frame_err <= 1'b1;
        end
      end

      if (scan_end_c && swap_pending_q) begin
        front_sel_q    <= ~front_sel_q;
        swap_pending_q <= 1'b0;
        disp_valid_q   <= 1'b1;
        frame_done     <= 1'b1;
      end
    end
  end

  // Pixel storage is deliberately not reset; disp_valid_q masks stale contents.
  always_ff @(posedge clk) begin
    if (byte_valid && !swap_pending_q && (ptr_q < PTR_W'(FRAME_BYTES))) begin
      buf_q[~front_sel_q][IDX_W'(ptr_q)] <= byte_data[7 -: BPC];
    end
  end

  assign show_c = (state_q == PWM) && enable && disp_valid_q;

  always_comb begin
    red_d   = '0;
    green_d = '0;
    blue_d  = '0;
    for (int unsigned c = 0; c < COLS; c++) begin
      red_d[c]   = show_c && (buf_q[front_sel_q][IDX_W'((32'(row_q) * COLS + c) * BYTES_PER_PIXEL + CH_R)] > slot_q);
      green_d[c] = show_c && (buf_q[front_sel_q][IDX_W'((32'(row_q) * COLS + c) * BYTES_PER_PIXEL + CH_G)] > slot_q);
      blue_d[c]  = show_c && (buf_q[front_sel_q][IDX_W'((32'(row_q) * COLS + c) * BYTES_PER_PIXEL + CH_B)] > slot_q);
    end
  end

  // Scan FSM; outputs are registered from the current scan position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= BLANK;
      row_q     <= '0;
      slot_q    <= '0;
      presc_q   <= '0;
      blank_q   <= '0;
      row_sel   <= '0;
      red_out   <= '0;
      green_out <= '0;
      blue_out  <= '0;
    end else begin
      row_sel   <= (state_q == PWM) ? (ROWS'(1) << row_q) : '0;
      red_out   <= red_d;
      green_out <= green_d;
      blue_out  <= blue_d;

      case (state_q)
        BLANK: begin
          if (blank_q == BLK_W'(BLANK_CYCLES - 1)) begin
            blank_q <= '0;
            slot_q  <= '0;
            presc_q <= '0;
            state_q <= PWM;
          end else begin
            blank_q <= blank_q + BLK_W'(1);
          end
        end
        PWM: begin
          if (presc_q == PRE_W'(PRESC - 1)) begin
            presc_q <= '0;
            if (slot_q == SLOT_W'(SLOTS - 1)) begin
              state_q <= BLANK;
              row_q   <= (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + ROW_W'(1);
            end else begin
              slot_q <= slot_q + SLOT_W'(1);
            end
          end else begin
            presc_q <= presc_q + PRE_W'(1);
          end
        end
        default: state_q <= BLANK;
      endcase
    end
  end

endmodule
